tof_peak_detector: RTL and testbench

Time-of-flight peak detector sitting directly downstream of the capture FIFO, on the AXI-Stream path that feeds the FIR. It consumes one post-trigger record of 16-bit ADC samples, one sample per beat. It tracks the maximum sample and its index within the record. At end of record it emits a single 32-bit result word (hit flag, short-frame flag, peak index, peak value) on an AXI-Stream master.

---
 rtl/tof_peak_detector.sv | 123 ++++++++++++
 tb/tb_tof_peak_detector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tof_peak_detector.sv
// Time-of-flight peak detector: finds the max sample and its index per record.
// Define TOF_ABS_EN to search on sample magnitude (-32768 saturates to 32767).
module tof_peak_detector #(
    parameter int RECORD_LEN = 1024,
    parameter int IDX_W      = $clog2(RECORD_LEN)
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_areset,
    input  logic        s00_axis_tvalid,
    input  logic        s00_axis_tlast,
    input  logic [31:0] s00_axis_tdata,
    output logic        s00_axis_tready,
    input  logic [15:0] threshold,
    input  logic        m00_axis_tready,
    output logic        m00_axis_tvalid,
    output logic        m00_axis_tlast,
    output logic [31:0] m00_axis_tdata,
    output logic [3:0]  m00_axis_tstrb
);

    typedef enum logic {ACCUM, REPORT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_LEN - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic signed [15:0] peak_q, peak_d;
    logic signed [15:0] thr_q, thr_d;
    logic               short_q, short_d;
    logic signed [15:0] raw, sample;
    logic               accept, last_beat, end_rec, hit;
    logic [13:0]        idx_ext;
    logic               unused_tdata;

    assign raw = s00_axis_tdata[15:0];
    assign unused_tdata = ^s00_axis_tdata[31:16];

`ifdef TOF_ABS_EN
    always_comb begin
        sample = raw;
        if (raw == -16'sd32768) begin
            sample = 16'sd32767;
        end else if (raw[15]) begin
            sample = -raw;
        end
    end
`else
    assign sample = raw;
`endif

    assign accept    = (state_q == ACCUM) && s00_axis_tvalid;
    assign last_beat = (count_q == LAST_IDX);
    assign end_rec   = accept && (s00_axis_tlast || last_beat);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        peak_d  = peak_q;
        thr_d   = thr_q;
        short_d = short_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    // First beat seeds the search and freezes the threshold
                    if (count_q == '0) begin
                        peak_d = sample;
                        idx_d  = '0;
                        thr_d  = threshold;
                    end else if (sample > peak_q) begin
                        peak_d = sample;
                        idx_d  = count_q;
                    end
                    if (end_rec) begin
                        count_d = '0;
                        short_d = !last_beat;
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                if (m00_axis_tready) begin
                    state_d = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q <= ACCUM;
            count_q <= '0;
            idx_q   <= '0;
            peak_q  <= '0;
            thr_q   <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            peak_q  <= peak_d;
            thr_q   <= thr_d;
            short_q <= short_d;
        end
    end

    assign hit = (peak_q >= thr_q);

    always_comb begin
        idx_ext = '0;
        idx_ext[IDX_W-1:0] = idx_q;
    end

    assign s00_axis_tready = (state_q == ACCUM);
    assign m00_axis_tvalid = (state_q == REPORT);
    assign m00_axis_tlast  = (state_q == REPORT);
    assign m00_axis_tstrb  = 4'hF;
    assign m00_axis_tdata  = (state_q == REPORT) ?
                             {hit, short_q, idx_ext, peak_q} : 32'h0;

endmodule

// File: tb/tb_tof_peak_detector.sv
// Scoreboarded bench for tof_peak_detector with a list-based reference model.
// Build with TOF_ABS_EN defined to exercise the magnitude variant.
module tb_tof_peak_detector;

    localparam int LEN = 1024;

    typedef logic [15:0] smp_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tready;
    logic [15:0] threshold = '0;
    logic        m_ready;
    logic        m_tvalid;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;

    logic        ready_drv = 1'b1;
    logic        rand_rdy = 1'b0;
    logic        rr = 1'b1;
    bit          gaps = 1'b0;

    logic [31:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    assign m_ready = rand_rdy ? rr : ready_drv;

    always begin
        @(posedge clk);
        #1;
        rr = ($urandom_range(0, 2) != 0);
    end

    tof_peak_detector #(.RECORD_LEN(LEN)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tready (s_tready),
        .threshold       (threshold),
        .m00_axis_tready (m_ready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: earliest maximum over the record, magnitude if enabled
    function automatic logic [31:0] model(input smp_q_t s,
                                          input logic [15:0] thr,
                                          input bit sh);
        int pk = 0;
        int idx = 0;
        int v;
        bit hit;
        for (int i = 0; i < s.size(); i++) begin
            v = int'($signed(s[i]));
`ifdef TOF_ABS_EN
            if (v < 0) v = -v;
            if (v > 32767) v = 32767;
`endif
            if (i == 0 || v > pk) begin
                pk = v;
                idx = i;
            end
        end
        hit = (pk >= int'($signed(thr)));
        return {hit, sh, 14'(idx), 16'(pk)};
    endfunction

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got %h, expected none",
                         m_tdata);
            end else begin
                check("result", m_tdata, exp_q.pop_front());
                check("tlast", 32'(m_tlast), 32'd1);
                check("tstrb", 32'(m_tstrb), 32'hF);
            end
        end
    end

    // stop_after >= 0 aborts the record after that many beats
    task automatic send_rec(input smp_q_t s, input logic [15:0] thr,
                            input bit use_last, input bit push,
                            input int stop_after);
        int n = s.size();
        int nb = (stop_after >= 0) ? stop_after : n;
        int w;
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 5) == 0) begin
                s_tvalid = 1'b0;
                s_tlast = 1'b0;
                step();
            end
            s_tvalid = 1'b1;
            s_tdata = {16'($urandom), s[i]};
            s_tlast = (i == n - 1) && (n < LEN || use_last);
            threshold = (i == 0) ? thr : 16'($urandom);
            w = 0;
            while (!s_tready && w < 50) begin
                step();
                w++;
            end
            if (w >= 50) check("s_tready_timeout", 32'(s_tready), 32'd1);
            if (i == n - 1 && push) exp_q.push_back(model(s, thr, n < LEN));
            step();
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        if (stop_after < 0) begin
            check("latency_tvalid", 32'(m_tvalid), 32'd1);
            check("report_stall", 32'(s_tready), 32'd0);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_s_tready"}, 32'(s_tready), 32'd1);
        check({name, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        check({name, "_m_tlast"}, 32'(m_tlast), 32'd0);
        check({name, "_m_tdata"}, m_tdata, 32'd0);
    endtask

    function automatic logic [15:0] rnd_sample();
        int k = $urandom_range(0, 15);
        if (k == 0) return 16'h8000;
        if (k == 1) return 16'h7FFF;
        if (k == 2) return 16'h8001;
        return 16'($urandom);
    endfunction

    initial begin
        smp_q_t s;
        logic [31:0] held;
        int n;
        int w;

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("post_reset");

        s = {};
        for (int i = 0; i < LEN; i++) s.push_back(16'(i));
        send_rec(s, 16'd500, 1'b0, 1'b1, -1);
        step();

        s = {};
        for (int i = 0; i < LEN; i++) s.push_back(-16'sd100);
        s[10] = 16'd300;
        s[20] = 16'd300;
        send_rec(s, 16'd301, 1'b0, 1'b1, -1);
        step();

        s = '{16'd5, 16'd9, 16'd2, 16'd7, 16'd1, 16'd0, 16'd3, 16'd4};
        send_rec(s, 16'd0, 1'b0, 1'b1, -1);
        s = '{16'd1, 16'd2, 16'd50, 16'd3};
        send_rec(s, 16'd60, 1'b0, 1'b1, -1);
        step();

        s = {};
        for (int i = 0; i < LEN; i++) s.push_back(16'($urandom_range(0, 900)));
        send_rec(s, 16'd100, 1'b1, 1'b1, -1);
        step();

        ready_drv = 1'b0;
        s = '{16'd3, 16'hFFF0, 16'd77, 16'd12};
        send_rec(s, 16'd10, 1'b0, 1'b1, -1);
        held = m_tdata;
        for (int i = 0; i < 20; i++) begin
            check("bp_stable", m_tdata, held);
            check("bp_s_tready", 32'(s_tready), 32'd0);
            check("bp_m_tvalid", 32'(m_tvalid), 32'd1);
            step();
        end
        ready_drv = 1'b1;
        step();
        check("bp_release_s_tready", 32'(s_tready), 32'd1);
        check("bp_release_m_tvalid", 32'(m_tvalid), 32'd0);

        s = {};
        for (int i = 0; i < LEN; i++) s.push_back(16'($urandom));
        send_rec(s, 16'd0, 1'b0, 1'b0, 300);
        rst = 1'b1;
        step();
        check_idle("abort_reset");
        rst = 1'b0;
        step();
        s = {};
        for (int i = 0; i < LEN; i++) s.push_back(16'($urandom_range(0, 41)));
        s[7] = 16'd42;
        send_rec(s, 16'd40, 1'b0, 1'b1, -1);
        step();

        ready_drv = 1'b0;
        s = '{16'd8, 16'd6, 16'd4};
        send_rec(s, 16'd0, 1'b0, 1'b0, -1);
        step();
        rst = 1'b1;
        #1;
        check("report_reset_tvalid", 32'(m_tvalid), 32'd0);
        step();
        rst = 1'b0;
        ready_drv = 1'b1;
        step();
        check_idle("report_reset");

`ifdef TOF_ABS_EN
        s = {};
        for (int i = 0; i < LEN; i++) s.push_back(16'd1000);
        s[3] = 16'h8000;
        send_rec(s, 16'd2000, 1'b0, 1'b1, -1);
        step();
`endif

        gaps = 1'b1;
        rand_rdy = 1'b1;
        for (int r = 0; r < 10; r++) begin
            n = (r % 4 == 0) ? LEN : $urandom_range(2, 200);
            s = {};
            for (int i = 0; i < n; i++) s.push_back(rnd_sample());
            send_rec(s, rnd_sample(), r[0], 1'b1, -1);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            step();
            w++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        rand_rdy = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
